// File: rtl/patid_stream_checker.sv
// Observes AW/AR handshakes on the tagger master port and checks each PATID against a
// region table. Optional feature macro: PATID_CHECKER_MISS_EN (unmatched address = mismatch).
module patid_stream_checker #(
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_USER_W      = 8,
  parameter int unsigned AXI_USER_ID_MSB = 7,
  parameter int unsigned AXI_USER_ID_LSB = 0,
  parameter int unsigned NUM_ADDR_CONF   = 4,
  parameter int unsigned CNT_W           = 16,
  // One channel is {user, addr, valid}; slv_req_i = {ar, aw}, slv_resp_i = {ar_ready, aw_ready}.
  localparam int unsigned CHAN_W = AXI_USER_W + AXI_ADDR_W + 1,
  localparam int unsigned REQ_W  = 2 * CHAN_W,
  // One region entry is {addr, size, patid}; entry 0 sits in the low bits.
  localparam int unsigned CONF_W = 2 * AXI_ADDR_W + AXI_USER_W
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REQ_W-1:0]                  slv_req_i,
  input  logic [1:0]                        slv_resp_i,
  input  logic [1:0]                        mode_i,
  input  logic [NUM_ADDR_CONF*CONF_W-1:0]   addr_conf_i,
  input  logic                              clear_i,
  output logic                              aw_error_o,
  output logic                              ar_error_o,
  output logic [AXI_USER_W-1:0]             aw_patid_ref_o,
  output logic [AXI_USER_W-1:0]             ar_patid_ref_o,
  output logic [AXI_USER_W-1:0]             aw_patid_act_o,
  output logic [AXI_USER_W-1:0]             ar_patid_act_o,
  output logic                              stable_err_o,
  output logic [CNT_W-1:0]                  err_cnt_o,
  output logic                              first_err_vld_o,
  output logic [AXI_ADDR_W-1:0]             first_err_addr_o,
  output logic                              first_err_is_ar_o
);

  localparam int CH_AW = 0;
  localparam int CH_AR = 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_TOR   = 2'b01,
    MODE_NA4   = 2'b10,
    MODE_NAPOT = 2'b11
  } mode_e;

  typedef struct packed {
    logic [AXI_USER_W-1:0] user;
    logic [AXI_ADDR_W-1:0] addr;
    logic                  valid;
  } chan_t;

  typedef struct packed {
    logic                  hit;
    logic [AXI_USER_W-1:0] patid;
  } lookup_t;

  // Walks the table from the top so the lowest matching index is the one left standing.
  // Bounds are held one bit wider than the address so base+size cannot wrap.
  function automatic lookup_t region_lookup(
    input logic [AXI_ADDR_W-1:0]             addr,
    input mode_e                             mode,
    input logic [NUM_ADDR_CONF*CONF_W-1:0]   conf
  );
    lookup_t             res;
    logic [AXI_ADDR_W:0] probe;
    logic [AXI_ADDR_W:0] base;
    logic [AXI_ADDR_W:0] top;
    logic                in_range;
    res   = '0;
    probe = {1'b0, addr};
    for (int i = NUM_ADDR_CONF - 1; i >= 0; i--) begin
      base = {1'b0, conf[i*CONF_W + AXI_USER_W + AXI_ADDR_W +: AXI_ADDR_W]};
      case (mode)
        MODE_TOR: begin
          top      = base;
          in_range = (probe <= top);
        end
        MODE_NA4: begin
          top      = base + (AXI_ADDR_W + 1)'(3);
          in_range = (probe >= base) && (probe <= top);
        end
        MODE_NAPOT: begin
          top      = base + {1'b0, conf[i*CONF_W + AXI_USER_W +: AXI_ADDR_W]};
          in_range = (probe >= base) && (probe <= top);
        end
        default: begin
          top      = base;
          in_range = 1'b0;
        end
      endcase
      if (in_range) begin
        res.hit   = 1'b1;
        res.patid = conf[i*CONF_W +: AXI_USER_W];
      end
    end
    return res;
  endfunction

  mode_e mode;
  chan_t chan  [2];
  logic  ready [2];

  assign mode      = mode_e'(mode_i);
  assign chan[CH_AW]  = slv_req_i[CHAN_W-1:0];
  assign chan[CH_AR]  = slv_req_i[REQ_W-1:CHAN_W];
  assign ready[CH_AW] = slv_resp_i[0];
  assign ready[CH_AR] = slv_resp_i[1];

  // Registered state
  logic                  err_q       [2];
  logic [AXI_USER_W-1:0] ref_q       [2];
  logic [AXI_USER_W-1:0] act_q       [2];
  logic                  hold_vld_q  [2];
  logic [AXI_ADDR_W-1:0] hold_addr_q [2];
  logic [AXI_USER_W-1:0] hold_user_q [2];
  logic                  stable_err_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  first_vld_q;
  logic [AXI_ADDR_W-1:0] first_addr_q;
  logic                  first_is_ar_q;

  // Combinational check results
  lookup_t               lookup      [2];
  logic [AXI_USER_W-1:0] obs_patid   [2];
  logic [AXI_USER_W-1:0] exp_patid   [2];
  logic                  mismatch    [2];
  logic                  unstable    [2];
  logic [CNT_W:0]        cnt_sum;
  logic [CNT_W-1:0]      cnt_next;

  // NOTE: every signal driven here gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    lookup    = '{default: '0};
    obs_patid = '{default: '0};
    exp_patid = '{default: '0};
    mismatch  = '{default: 1'b0};
    unstable  = '{default: 1'b0};
    for (int c = 0; c < 2; c++) begin
      obs_patid[c] = AXI_USER_W'(chan[c].user[AXI_USER_ID_MSB:AXI_USER_ID_LSB]);
      lookup[c]    = region_lookup(chan[c].addr, mode, addr_conf_i);
      if (chan[c].valid && ready[c] && (mode != MODE_OFF)) begin
        if (lookup[c].hit) begin
          mismatch[c]  = (lookup[c].patid != obs_patid[c]);
          exp_patid[c] = lookup[c].patid;
        end
`ifdef PATID_CHECKER_MISS_EN
        else begin
          mismatch[c]  = 1'b1;
          exp_patid[c] = '0;
        end
`endif
      end
      // A stalled beat must come back unchanged, and must not be withdrawn.
      unstable[c] = hold_vld_q[c] &&
                    (!chan[c].valid ||
                     (chan[c].addr != hold_addr_q[c]) ||
                     (chan[c].user != hold_user_q[c]));
    end

    cnt_sum  = {1'b0, cnt_q} + (CNT_W + 1)'(mismatch[CH_AW]) + (CNT_W + 1)'(mismatch[CH_AR]);
    cnt_next = (cnt_sum > {1'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before this edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q         <= '{default: 1'b0};
      ref_q         <= '{default: '0};
      act_q         <= '{default: '0};
      hold_vld_q    <= '{default: 1'b0};
      hold_addr_q   <= '{default: '0};
      hold_user_q   <= '{default: '0};
      stable_err_q  <= 1'b0;
      cnt_q         <= '0;
      first_vld_q   <= 1'b0;
      first_addr_q  <= '0;
      first_is_ar_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        err_q[c]      <= mismatch[c];
        hold_vld_q[c] <= chan[c].valid && !ready[c];
        if (mismatch[c]) begin
          ref_q[c] <= exp_patid[c];
          act_q[c] <= obs_patid[c];
        end
        if (chan[c].valid && !ready[c]) begin
          hold_addr_q[c] <= chan[c].addr;
          hold_user_q[c] <= chan[c].user;
        end
      end

      // clear_i wins over anything counted or captured this cycle; the pulse is unaffected.
      if (clear_i) begin
        stable_err_q  <= 1'b0;
        cnt_q         <= '0;
        first_vld_q   <= 1'b0;
        first_addr_q  <= '0;
        first_is_ar_q <= 1'b0;
      end else begin
        cnt_q <= cnt_next;
        if (unstable[CH_AW] || unstable[CH_AR]) begin
          stable_err_q <= 1'b1;
        end
        if (!first_vld_q && (mismatch[CH_AW] || mismatch[CH_AR])) begin
          first_vld_q   <= 1'b1;
          first_addr_q  <= mismatch[CH_AW] ? chan[CH_AW].addr : chan[CH_AR].addr;
          first_is_ar_q <= !mismatch[CH_AW];
        end
      end
    end
  end

  assign aw_error_o        = err_q[CH_AW];
  assign ar_error_o        = err_q[CH_AR];
  assign aw_patid_ref_o    = ref_q[CH_AW];
  assign ar_patid_ref_o    = ref_q[CH_AR];
  assign aw_patid_act_o    = act_q[CH_AW];
  assign ar_patid_act_o    = act_q[CH_AR];
  assign stable_err_o      = stable_err_q;
  assign err_cnt_o         = cnt_q;
  assign first_err_vld_o   = first_vld_q;
  assign first_err_addr_o  = first_addr_q;
  assign first_err_is_ar_o = first_is_ar_q;

endmodule

// File: tb/tb_patid_stream_checker.sv
// Bench for patid_stream_checker: directed vector table, multi-cycle corner sequences and a
// randomized run against an address/PATID reference model. Honours PATID_CHECKER_MISS_EN.
module tb_patid_stream_checker;

  localparam int ADDR_W = 32;
  localparam int USER_W = 8;
  localparam int NCONF  = 4;
  localparam int CONF_W = 2 * ADDR_W + USER_W;
  localparam int REQ_W  = 2 * (USER_W + ADDR_W + 1);

`ifdef PATID_CHECKER_MISS_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  localparam logic [1:0] M_OFF = 2'b00, M_TOR = 2'b01, M_NA4 = 2'b10, M_NAPOT = 2'b11;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              aw_valid = 0, aw_ready = 0, ar_valid = 0, ar_ready = 0;
  logic [ADDR_W-1:0] aw_addr = '0, ar_addr = '0;
  logic [USER_W-1:0] aw_user = '0, ar_user = '0;
  logic [1:0]        mode = M_OFF;
  logic              clear_i = 1'b0;
  logic [ADDR_W-1:0] c_addr [NCONF];
  logic [ADDR_W-1:0] c_size [NCONF];
  logic [USER_W-1:0] c_pat  [NCONF];

  logic [REQ_W-1:0]        slv_req;
  logic [1:0]              slv_resp;
  logic [NCONF*CONF_W-1:0] addr_conf;

  assign slv_req  = {ar_user, ar_addr, ar_valid, aw_user, aw_addr, aw_valid};
  assign slv_resp = {ar_ready, aw_ready};

  always_comb begin
    addr_conf = '0;
    for (int i = 0; i < NCONF; i++) addr_conf[i*CONF_W +: CONF_W] = {c_addr[i], c_size[i], c_pat[i]};
  end

  logic              aw_error, ar_error, stable_err, first_vld, first_is_ar;
  logic [USER_W-1:0] aw_ref, ar_ref, aw_act, ar_act;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] first_addr;

  logic              s_aw_error, s_ar_error, s_stable_err, s_first_vld, s_first_is_ar;
  logic [USER_W-1:0] s_aw_ref, s_ar_ref, s_aw_act, s_ar_act;
  logic [1:0]        s_err_cnt;
  logic [ADDR_W-1:0] s_first_addr;

  patid_stream_checker u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .slv_req_i(slv_req), .slv_resp_i(slv_resp),
    .mode_i(mode), .addr_conf_i(addr_conf), .clear_i(clear_i),
    .aw_error_o(aw_error), .ar_error_o(ar_error),
    .aw_patid_ref_o(aw_ref), .ar_patid_ref_o(ar_ref),
    .aw_patid_act_o(aw_act), .ar_patid_act_o(ar_act),
    .stable_err_o(stable_err), .err_cnt_o(err_cnt),
    .first_err_vld_o(first_vld), .first_err_addr_o(first_addr), .first_err_is_ar_o(first_is_ar)
  );

  // Narrow-counter instance on the same stimulus for saturation behaviour.
  patid_stream_checker #(.CNT_W(2)) u_dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .slv_req_i(slv_req), .slv_resp_i(slv_resp),
    .mode_i(mode), .addr_conf_i(addr_conf), .clear_i(clear_i),
    .aw_error_o(s_aw_error), .ar_error_o(s_ar_error),
    .aw_patid_ref_o(s_aw_ref), .ar_patid_ref_o(s_ar_ref),
    .aw_patid_act_o(s_aw_act), .ar_patid_act_o(s_ar_act),
    .stable_err_o(s_stable_err), .err_cnt_o(s_err_cnt),
    .first_err_vld_o(s_first_vld), .first_err_addr_o(s_first_addr), .first_err_is_ar_o(s_first_is_ar)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_conf0(input logic [31:0] a, input logic [31:0] s, input logic [7:0] p);
    c_addr[0] = a; c_size[0] = s; c_pat[0] = p;
    for (int i = 1; i < NCONF; i++) begin
      c_addr[i] = 32'hFFFF_0000; c_size[i] = '0; c_pat[i] = 8'hEE;
    end
  endtask

  task automatic idle_clear();
    aw_valid = 0; ar_valid = 0; clear_i = 1; tick(); clear_i = 0;
  endtask

  // ---------------- reference model ----------------
  bit          m_err [2];
  logic [7:0]  m_ref [2], m_act [2];
  int unsigned m_cnt, m_cnt_sat;
  bit          m_fvld, m_fis_ar, m_stable;
  logic [31:0] m_faddr;
  bit          p_valid [2], p_ready [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_user [2];

  function automatic void model_reset();
    m_err = '{0, 0}; m_ref = '{0, 0}; m_act = '{0, 0};
    m_cnt = 0; m_cnt_sat = 0; m_fvld = 0; m_fis_ar = 0; m_stable = 0; m_faddr = 0;
    p_valid = '{0, 0}; p_ready = '{0, 0}; p_addr = '{0, 0}; p_user = '{0, 0};
  endfunction

  function automatic void m_lookup(input logic [1:0] md, input logic [31:0] addr,
                                   output bit hit, output logic [7:0] pat);
    longint a, lo, hi;
    hit = 0; pat = 0;
    a = longint'(addr);
    for (int i = 0; i < NCONF; i++) begin
      lo = longint'(c_addr[i]);
      hi = (md == M_NA4) ? lo + 3 : lo + longint'(c_size[i]);
      if ((md == M_TOR && a <= lo) || (md != M_TOR && md != M_OFF && a >= lo && a <= hi)) begin
        hit = 1; pat = c_pat[i];
        return;
      end
    end
  endfunction

  // Predicts the outputs visible after the coming clock edge from the current inputs.
  function automatic void model_step();
    bit v[2], r[2], mis[2], hit, viol;
    logic [31:0] a[2];
    logic [7:0]  u[2], pat;
    int n;
    v = '{aw_valid, ar_valid}; r = '{aw_ready, ar_ready};
    a = '{aw_addr, ar_addr};   u = '{aw_user, ar_user};
    viol = 0;
    for (int c = 0; c < 2; c++) begin
      mis[c] = 0;
      if (v[c] && r[c] && mode != M_OFF) begin
        m_lookup(mode, a[c], hit, pat);
        if (hit && pat != u[c]) begin
          mis[c] = 1; m_ref[c] = pat; m_act[c] = u[c];
        end else if (!hit && MISS_EN) begin
          mis[c] = 1; m_ref[c] = 0; m_act[c] = u[c];
        end
      end
      m_err[c] = mis[c];
      if (p_valid[c] && !p_ready[c] && (!v[c] || a[c] != p_addr[c] || u[c] != p_user[c])) viol = 1;
      p_valid[c] = v[c]; p_ready[c] = r[c]; p_addr[c] = a[c]; p_user[c] = u[c];
    end
    if (clear_i) begin
      m_cnt = 0; m_cnt_sat = 0; m_fvld = 0; m_faddr = 0; m_fis_ar = 0; m_stable = 0;
    end else begin
      n = int'(mis[0]) + int'(mis[1]);
      m_cnt     = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
      m_cnt_sat = (m_cnt_sat + n > 3) ? 3 : m_cnt_sat + n;
      if (viol) m_stable = 1;
      if (!m_fvld && n > 0) begin
        m_fvld = 1; m_fis_ar = !mis[0]; m_faddr = mis[0] ? a[0] : a[1];
      end
    end
  endfunction

  task automatic check_all();
    check("rnd_aw_err", aw_error, m_err[0]);
    check("rnd_ar_err", ar_error, m_err[1]);
    check("rnd_aw_ref", aw_ref, m_ref[0]);
    check("rnd_aw_act", aw_act, m_act[0]);
    check("rnd_ar_ref", ar_ref, m_ref[1]);
    check("rnd_ar_act", ar_act, m_act[1]);
    check("rnd_stable", stable_err, m_stable);
    check("rnd_cnt", err_cnt, m_cnt);
    check("rnd_cnt_sat", s_err_cnt, m_cnt_sat);
    check("rnd_fvld", first_vld, m_fvld);
    check("rnd_faddr", first_addr, m_faddr);
    check("rnd_fis_ar", first_is_ar, m_fis_ar);
  endtask

  task automatic rnd_chan(input logic v_in, input logic r_in, input logic [31:0] a_in,
                          input logic [7:0] u_in, output logic v, output logic r,
                          output logic [31:0] a, output logic [7:0] u);
    int k;
    if (v_in && !r_in && $urandom_range(0, 9) != 0) begin
      v = 1; a = a_in; u = u_in;
    end else begin
      v = ($urandom_range(0, 2) != 0);
      k = $urandom_range(0, NCONF - 1);
      a = ($urandom_range(0, 4) == 0) ? 32'($urandom()) : c_addr[k] + 32'($urandom_range(0, 'h1100)) - 32'd8;
      u = 8'($urandom_range(0, 3));
    end
    r = ($urandom_range(0, 2) != 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [31:0] c_addr, c_size;
    logic [7:0]  c_pat;
    logic        aw_v;
    logic [31:0] aw_a;
    logic [7:0]  aw_u;
    logic        ar_v;
    logic [31:0] ar_a;
    logic [7:0]  ar_u;
    logic        rdy;
    logic        e_aw, e_ar;
    logic [7:0]  e_aw_ref, e_aw_act, e_ar_ref, e_ar_act;
    int          e_cnt;
    logic        e_fvld;
    logic [31:0] e_faddr;
    logic        e_fis_ar;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{M_TOR, 32'h1000, 0, 3, 1, 32'h0800, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{M_TOR, 32'h1000, 0, 3, 0, 0, 0, 1, 32'h0800, 5, 1, 0, 1, 0, 0, 3, 5, 1, 1, 32'h0800, 1};
    vecs[2]  = '{M_NAPOT, 32'h2000, 32'hFF, 7, 1, 32'h2010, 1, 1, 32'h20FF, 2, 1, 1, 1, 7, 1, 7, 2, 2, 1, 32'h2010, 0};
    vecs[3]  = '{M_NAPOT, 32'h2000, 32'hFF, 7, 1, 32'h2100, 1, 0, 0, 0, 1, MISS_EN, 0, 0, 1, 0, 0,
                 int'(MISS_EN), MISS_EN, MISS_EN ? 32'h2100 : 32'h0, 0};
    vecs[4]  = '{M_NA4, 32'h100, 0, 4, 0, 0, 0, 1, 32'h103, 9, 1, 0, 1, 0, 0, 4, 9, 1, 1, 32'h103, 1};
    vecs[5]  = '{M_NA4, 32'h100, 0, 4, 0, 0, 0, 1, 32'h200, 1, 1, 0, MISS_EN, 0, 0, 0, 1,
                 int'(MISS_EN), MISS_EN, MISS_EN ? 32'h200 : 32'h0, MISS_EN};
    vecs[6]  = '{M_OFF, 32'h1000, 0, 3, 1, 32'h0800, 9, 1, 32'h0800, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{M_TOR, 32'h1000, 0, 3, 1, 32'h1001, 3, 0, 0, 0, 1, 1, 0, 8'hEE, 3, 0, 0, 1, 1, 32'h1001, 0};
    vecs[8]  = '{M_TOR, 32'h1000, 0, 3, 0, 0, 0, 1, 32'h1000, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{M_NAPOT, 32'hFFFF_FF00, 32'hFFFF_FFFF, 6, 1, 32'h10, 6, 1, 32'hFFFF_FFF0, 2, 1, MISS_EN, 1,
                 0, 6, 6, 2, MISS_EN ? 2 : 1, 1, MISS_EN ? 32'h10 : 32'hFFFF_FFF0, !MISS_EN};
    vecs[10] = '{M_TOR, 32'h1000, 0, 3, 0, 0, 0, 1, 32'h0800, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    set_conf0(32'h1000, 0, 3);

    // Reset: handshakes and a stall presented during reset leave no trace.
    rst_i = 1; mode = M_TOR;
    aw_valid = 1; aw_addr = 32'h0800; aw_user = 9; aw_ready = 0;
    ar_valid = 1; ar_addr = 32'h0800; ar_user = 9; ar_ready = 1;
    tick(); tick();
    check("rst_aw_err", aw_error, 0);
    check("rst_ar_err", ar_error, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_fvld", first_vld, 0);
    check("rst_stable", stable_err, 0);
    check("rst_ref_act", {aw_ref, aw_act, ar_ref, ar_act}, 0);
    rst_i = 0; aw_valid = 0; ar_valid = 0;
    tick();
    check("rst_hold_cleared", stable_err, 0);

    for (int i = 0; i < $size(vecs); i++) begin
      mode = vecs[i].mode;
      set_conf0(vecs[i].c_addr, vecs[i].c_size, vecs[i].c_pat);
      idle_clear();
      aw_valid = vecs[i].aw_v; aw_addr = vecs[i].aw_a; aw_user = vecs[i].aw_u; aw_ready = vecs[i].rdy;
      ar_valid = vecs[i].ar_v; ar_addr = vecs[i].ar_a; ar_user = vecs[i].ar_u; ar_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_aw_err", i), aw_error, vecs[i].e_aw);
      check($sformatf("vec%0d_ar_err", i), ar_error, vecs[i].e_ar);
      if (vecs[i].e_aw) begin
        check($sformatf("vec%0d_aw_ref", i), aw_ref, vecs[i].e_aw_ref);
        check($sformatf("vec%0d_aw_act", i), aw_act, vecs[i].e_aw_act);
      end
      if (vecs[i].e_ar) begin
        check($sformatf("vec%0d_ar_ref", i), ar_ref, vecs[i].e_ar_ref);
        check($sformatf("vec%0d_ar_act", i), ar_act, vecs[i].e_ar_act);
      end
      check($sformatf("vec%0d_cnt", i), err_cnt, vecs[i].e_cnt);
      check($sformatf("vec%0d_cnt_sat", i), s_err_cnt, (vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt);
      check($sformatf("vec%0d_fvld", i), first_vld, vecs[i].e_fvld);
      check($sformatf("vec%0d_faddr", i), first_addr, vecs[i].e_faddr);
      check($sformatf("vec%0d_fis_ar", i), first_is_ar, vecs[i].e_fis_ar);
      check($sformatf("vec%0d_stable", i), stable_err, 0);
    end
    idle_clear();

    // Stall stability: address changes on the second stalled cycle.
    mode = M_TOR; set_conf0(32'h1000, 0, 3);
    aw_valid = 1; aw_ready = 0; aw_addr = 32'h1000; aw_user = 3;
    tick(); check("stab_first_stall", stable_err, 0);
    aw_addr = 32'h1004;
    tick(); check("stab_addr_change", stable_err, 1);
    tick(); check("stab_still_stalled", stable_err, 1);
    aw_ready = 1;
    tick(); aw_valid = 0;
    tick(); tick(); check("stab_sticky", stable_err, 1);
    idle_clear(); check("stab_cleared", stable_err, 0);

    // Valid withdrawn before the handshake.
    ar_valid = 1; ar_ready = 0; ar_addr = 32'h0800; ar_user = 3;
    tick(); check("stab_drop_pre", stable_err, 0);
    ar_valid = 0;
    tick(); check("stab_drop", stable_err, 1);
    idle_clear();

    // User changes exactly at the handshake; then a clean stall.
    aw_valid = 1; aw_ready = 0; aw_addr = 32'h0800; aw_user = 3;
    tick(); aw_user = 4; aw_ready = 1;
    tick(); check("stab_user_at_hs", stable_err, 1);
    idle_clear();
    ar_valid = 1; ar_ready = 0; ar_addr = 32'h0900; ar_user = 3;
    tick(); tick(); ar_ready = 1;
    tick(); ar_valid = 0;
    tick(); check("stab_clean", stable_err, 0);

    // Saturation of the narrow counter, then clear racing a sixth mismatch.
    idle_clear();
    ar_valid = 1; ar_ready = 1; ar_addr = 32'h0800; ar_user = 5;
    for (int k = 0; k < 5; k++) tick();
    check("sat_cnt5", s_err_cnt, 3);
    check("sat_wide_cnt5", err_cnt, 5);
    clear_i = 1;
    tick(); clear_i = 0; ar_valid = 0;
    check("sat_clear_cnt", s_err_cnt, 0);
    check("sat_clear_fvld", s_first_vld, 0);
    check("sat_clear_pulse", s_ar_error, 1);
    check("clear_wide_cnt", err_cnt, 0);

    // Double mismatch steps by two and saturates from 2.
    aw_valid = 1; aw_ready = 1; aw_addr = 32'h0700; aw_user = 6;
    ar_valid = 1; ar_ready = 1; ar_addr = 32'h0600; ar_user = 7;
    tick();
    check("dbl_cnt", err_cnt, 2);
    check("dbl_sat_cnt", s_err_cnt, 2);
    check("dbl_fis_ar", first_is_ar, 0);
    check("dbl_faddr", first_addr, 32'h0700);
    tick();
    check("dbl2_sat_cnt", s_err_cnt, 3);
    check("dbl2_cnt", err_cnt, 4);

    // OFF freezes checking but stability stays live.
    mode = M_OFF;
    tick();
    check("off_no_pulse", {aw_error, ar_error}, 0);
    check("off_cnt_frozen", err_cnt, 4);
    ar_valid = 0; aw_ready = 0; aw_addr = 32'h0100;
    tick(); aw_addr = 32'h0104;
    tick(); check("off_stab", stable_err, 1);
    aw_valid = 0;

    // Randomized run against the model.
    rst_i = 1; clear_i = 0;
    tick();
    rst_i = 0;
    model_reset();
    check_all();
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < NCONF; i++) begin
          c_addr[i] = 32'($urandom_range(0, 15)) << 12;
          case ($urandom_range(0, 4))
            0: c_size[i] = 0;
            1: c_size[i] = 32'h3;
            2: c_size[i] = 32'hFF;
            3: c_size[i] = 32'hFFF;
            default: c_size[i] = 32'hFFFF_FFFF;
          endcase
          c_pat[i] = 8'($urandom_range(0, 3));
        end
      end
      rnd_chan(aw_valid, aw_ready, aw_addr, aw_user, aw_valid, aw_ready, aw_addr, aw_user);
      rnd_chan(ar_valid, ar_ready, ar_addr, ar_user, ar_valid, ar_ready, ar_addr, ar_user);
      clear_i = ($urandom_range(0, 39) == 0);
      model_step();
      tick();
      check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
